fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core. Owns the program counter, drives the instruction ROM's combinational read port and registers the returned word together with its PC into the IF/ID pipeline register consumed by decode. Handles stall from downstream, branch/jump redirects, halt, and out-of-range fetch addresses.

## Interface

- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; bits [1:0] must be zero.
- `ROM_ADDR_BITS`, default `16`: byte-address width of the ROM; equals `$bits(RomAddress)`.
- `NOP_WORD`, default `32'h0000_0013`: instruction substituted on a fetch fault (`addi x0,x0,0`).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rom_address`  out  ROM_ADDR_BITS  byte address to ROM; combinational `pc[ROM_ADDR_BITS-1:0]`.
- `rom_data`  in  32  word returned combinationally by ROM for `rom_address`.
- `stall`  in  1  decode cannot accept; hold PC and the IF/ID register.
- `redirect_valid`  in  1  taken branch/jump resolved downstream.
- `redirect_target`  in  32  new PC when `redirect_valid`.
- `halt`  in  1  ebreak/ecall retired; stop fetching.
- `if_valid`  out  1  IF/ID register holds a real instruction.
- `if_pc`  out  32  PC of `if_instr`.
- `if_instr`  out  32  fetched instruction.
- `if_fault`  out  1  `if_instr` is `NOP_WORD` substituted for an out-of-range fetch.

## Operation

- State machine, states `BOOT`, `RUN`, `HALTED`.
  - `reset` -> `BOOT`, `pc <= RESET_PC`, `if_valid<=0`, `if_pc<=0`, `if_instr<=NOP_WORD`, `if_fault<=0`.
  - `BOOT` -> `RUN` unconditionally next edge; no fetch registered (one guaranteed bubble after reset).
  - `RUN`: each non-stalled edge registers `{pc, rom_data}` into IF/ID with `if_valid<=1`, and `pc <= pc + 4` (32-bit, wraps `FFFF_FFFC -> 0`).
  - `RUN` + `halt` -> `HALTED`: `if_valid<=0`, PC held.
  - `HALTED`: PC and IF/ID held with `if_valid=0`; only `redirect_valid` (-> `RUN`) or `reset` exits.
- Priority per edge: `reset` > `redirect_valid` > `halt` > `stall` > normal advance.
- Redirect: `pc <= {redirect_target[31:2], 2'b00}` (low bits dropped), `if_valid<=0` (squash wrong-path word), state `RUN`; applies even if `stall` is high.
- Stall (no redirect/halt): PC, IF/ID and state all hold unchanged.
- Fault: if `pc[31:ROM_ADDR_BITS]` is nonzero, the registered word is `NOP_WORD` with `if_fault<=1`, `if_valid<=1`; PC still advances. Otherwise `if_fault<=0`.
- `rom_address` always reflects current `pc`, including during stall/halt.

## Timing

- Fetch latency: 1 cycle; PC present on `rom_address` in cycle N appears on `if_pc`/`if_instr` after edge N.
- Redirect asserted in cycle N: after edge N `if_valid=0`, `pc=target`; target instruction valid after edge N+1. Branch penalty = 1 bubble from this stage.
- First valid instruction after reset deasserts: after the 2nd rising edge (BOOT then fetch of `RESET_PC`).
- Stall is zero-latency: registers held on the same edge `stall` is sampled high.
- `halt` and `stall` together: halt wins, `if_valid<=0`.
- Reset mid-stall or mid-halt: fully reinitialises on that edge, pending redirect discarded.
- No combinational path from `stall`/`redirect_*`/`halt` to `rom_address`.

## Test plan

- Reset, ROM words 0..3 = `11,22,33,44`, no stall -> cycle 1 `if_valid=0`; then `if_pc=0,4,8,C` with `if_instr=11,22,33,44`, one per cycle.
- Stall held 3 cycles while `if_pc=4` -> `if_pc=4`, `if_instr=22`, `rom_address=8` constant; release -> `if_pc=8` next edge.
- `redirect_valid` with target `0x23` while `stall=1` -> next edge `if_valid=0`, `rom_address=0x20`; following edge `if_pc=0x20`, `if_valid=1`.
- `halt` at `if_pc=8` -> `if_valid=0` indefinitely, `rom_address` frozen; redirect to `0x0` -> resumes with `if_pc=0`.
- Redirect to `0x0001_0000` (ROM_ADDR_BITS=16) -> `if_instr=0x13`, `if_fault=1`, `if_valid=1`; next `if_pc=0x0001_0004` also faults.
- Reset asserted during halt with pending redirect -> after edge state `BOOT`, `rom_address=RESET_PC`, `if_valid=0`, redirect ignored.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, its instruction ROM and decode.
// The master side is the fetch stage; the slave side is the ROM/decode/control environment.
interface fetch_stage_if #(
    parameter int ROM_ADDR_BITS = 16
);
    logic [ROM_ADDR_BITS-1:0] rom_address;
    logic [31:0]              rom_data;
    logic                     stall;
    logic                     redirect_valid;
    logic [31:0]              redirect_target;
    logic                     halt;
    logic                     if_valid;
    logic [31:0]              if_pc;
    logic [31:0]              if_instr;
    logic                     if_fault;

    modport master (
        output rom_address,
        input  rom_data,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  halt,
        output if_valid,
        output if_pc,
        output if_instr,
        output if_fault
    );

    modport slave (
        input  rom_address,
        output rom_data,
        output stall,
        output redirect_valid,
        output redirect_target,
        output halt,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        input  if_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the ROM combinationally and registers
// {pc, instruction} into the IF/ID register, honouring stall, redirect, halt and fetch faults.
module fetch_stage #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          ROM_ADDR_BITS = 16,
    parameter logic [31:0] NOP_WORD      = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        bus
);
    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_if_fault;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_if_valid_nxt;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] w_if_instr_nxt;
    logic        w_if_fault_nxt;
    logic        w_fault;
    logic [31:0] w_redirect_pc;

    // Any PC bit above the ROM window means the address lies outside the ROM.
    function automatic logic pc_out_of_range(input logic [31:0] pc);
        logic [31:0] upper;
        upper = pc >> ROM_ADDR_BITS;
        return (upper != 32'h0000_0000);
    endfunction

    assign w_fault       = pc_out_of_range(r_pc);
    assign w_redirect_pc = {bus.redirect_target[31:2], 2'b00};

    // Next-state, next-PC and IF/ID update; hold everything unless an event says otherwise.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = r_if_valid;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = r_if_instr;
        w_if_fault_nxt = r_if_fault;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
                if (bus.redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt       = w_redirect_pc;
                    w_if_valid_nxt = 1'b0;
                end else if (bus.halt) begin
                    w_state_nxt    = HALTED;
                    w_if_valid_nxt = 1'b0;
                end else if (bus.stall) begin
                    w_state_nxt    = RUN;
                end else begin
                    w_if_valid_nxt = 1'b1;
                    w_if_pc_nxt    = r_pc;
                    w_if_instr_nxt = w_fault ? NOP_WORD : bus.rom_data;
                    w_if_fault_nxt = w_fault;
                    w_pc_nxt       = r_pc + 32'd4;
                end
            end
            HALTED: begin
                if (bus.redirect_valid) begin
                    w_state_nxt    = RUN;
                    w_pc_nxt       = w_redirect_pc;
                    w_if_valid_nxt = 1'b0;
                end else begin
                    w_if_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = BOOT;
                w_pc_nxt       = RESET_PC;
                w_if_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'h0000_0000;
            r_if_instr <= NOP_WORD;
            r_if_fault <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_fault <= w_if_fault_nxt;
        end
    end

    assign bus.rom_address = r_pc[ROM_ADDR_BITS-1:0];
    assign bus.if_valid    = r_if_valid;
    assign bus.if_pc       = r_if_pc;
    assign bus.if_instr    = r_if_instr;
    assign bus.if_fault    = r_if_fault;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: small ROM model, linear stimulus, hand-computed expectations.
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    fetch_stage_if #(.ROM_ADDR_BITS(16)) bus ();

    fetch_stage #(
        .RESET_PC      (32'h0000_0000),
        .ROM_ADDR_BITS (16),
        .NOP_WORD      (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words 0..3 are 11,22,33,44; everything else encodes its own address.
    function automatic logic [31:0] rom_read(input logic [15:0] addr);
        case (addr)
            16'h0000: return 32'h0000_0011;
            16'h0004: return 32'h0000_0022;
            16'h0008: return 32'h0000_0033;
            16'h000C: return 32'h0000_0044;
            default:  return {16'hA5A5, addr};
        endcase
    endfunction

    assign bus.rom_data = rom_read(bus.rom_address);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr, input logic flt, input logic [31:0] ra);
        chk({tag, ".valid"}, {31'd0, bus.if_valid}, {31'd0, v});
        chk({tag, ".pc"}, bus.if_pc, pc);
        chk({tag, ".instr"}, bus.if_instr, instr);
        chk({tag, ".fault"}, {31'd0, bus.if_fault}, {31'd0, flt});
        chk({tag, ".rom_addr"}, {16'd0, bus.rom_address}, ra);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0000_0000;
        bus.halt = 1'b0;
        step();
        chk_if("reset", 1'b0, 32'h0, 32'h13, 1'b0, 32'h0);
        reset = 1'b0;

        // Boot bubble then sequential fetch
        step(); chk_if("boot", 1'b0, 32'h0, 32'h13, 1'b0, 32'h0);
        step(); chk_if("f0", 1'b1, 32'h0, 32'h11, 1'b0, 32'h4);
        step(); chk_if("f4", 1'b1, 32'h4, 32'h22, 1'b0, 32'h8);

        // Stall for three cycles
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_if("stall", 1'b1, 32'h4, 32'h22, 1'b0, 32'h8);
        end
        bus.stall = 1'b0;
        step(); chk_if("f8", 1'b1, 32'h8, 32'h33, 1'b0, 32'hC);
        step(); chk_if("fC", 1'b1, 32'hC, 32'h44, 1'b0, 32'h10);

        // Redirect under stall, target low bits dropped
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0023;
        step(); chk_if("redir", 1'b0, 32'hC, 32'h44, 1'b0, 32'h20);
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        step(); chk_if("tgt20", 1'b1, 32'h20, 32'hA5A5_0020, 1'b0, 32'h24);

        // Back to 0, advance to pc 8, then halt together with stall
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0000;
        step(); chk_if("redir0", 1'b0, 32'h20, 32'hA5A5_0020, 1'b0, 32'h0);
        bus.redirect_valid = 1'b0;
        step(); chk_if("h0", 1'b1, 32'h0, 32'h11, 1'b0, 32'h4);
        step(); chk_if("h4", 1'b1, 32'h4, 32'h22, 1'b0, 32'h8);
        step(); chk_if("h8", 1'b1, 32'h8, 32'h33, 1'b0, 32'hC);
        bus.halt = 1'b1;
        bus.stall = 1'b1;
        step(); chk_if("halt", 1'b0, 32'h8, 32'h33, 1'b0, 32'hC);
        bus.halt = 1'b0;
        bus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_if("halted", 1'b0, 32'h8, 32'h33, 1'b0, 32'hC);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0000;
        step(); chk_if("resume", 1'b0, 32'h8, 32'h33, 1'b0, 32'h0);
        bus.redirect_valid = 1'b0;
        step(); chk_if("resume0", 1'b1, 32'h0, 32'h11, 1'b0, 32'h4);

        // Out-of-range fetch substitutes NOP
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0001_0000;
        step(); chk_if("redir_oor", 1'b0, 32'h0, 32'h11, 1'b0, 32'h0);
        bus.redirect_valid = 1'b0;
        step(); chk_if("fault0", 1'b1, 32'h0001_0000, 32'h13, 1'b1, 32'h4);
        step(); chk_if("fault4", 1'b1, 32'h0001_0004, 32'h13, 1'b1, 32'h8);

        // PC wrap from FFFF_FFFC to 0
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFF;
        step(); chk_if("redir_top", 1'b0, 32'h0001_0004, 32'h13, 1'b1, 32'hFFFC);
        bus.redirect_valid = 1'b0;
        step(); chk_if("top", 1'b1, 32'hFFFF_FFFC, 32'h13, 1'b1, 32'h0);
        step(); chk_if("wrap", 1'b1, 32'h0, 32'h11, 1'b0, 32'h4);

        // Reset during halt with a pending redirect
        bus.halt = 1'b1;
        step(); chk_if("halt2", 1'b0, 32'h0, 32'h11, 1'b0, 32'h4);
        bus.halt = 1'b0;
        reset = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0000_0040;
        step(); chk_if("reset_halt", 1'b0, 32'h0, 32'h13, 1'b0, 32'h0);
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        step(); chk_if("boot2", 1'b0, 32'h0, 32'h13, 1'b0, 32'h0);
        step(); chk_if("refetch0", 1'b1, 32'h0, 32'h11, 1'b0, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
